// File: rtl/core_pkg.sv
// Shared core types for the EXEC->MEM interface and the MEM stage FSM.
package core_pkg;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_dir_e;

    typedef enum logic [2:0] {
        MEM_BYTE   = 3'd0,
        MEM_HALF   = 3'd1,
        MEM_WORD   = 3'd2,
        MEM_BYTE_U = 3'd3,
        MEM_HALF_U = 3'd4
    } mem_size_e;

    typedef enum logic [1:0] {
        RSV_NONE  = 2'd0,
        RSV_SET   = 2'd1,
        RSV_CLEAR = 2'd2
    } mem_rsv_e;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2
    } mem_state_e;

endpackage

// File: rtl/core_mem_lane.sv
// Byte-lane steering: store strobe/replication and load extract/extend.
module core_mem_lane
    import core_pkg::*;
(
    input  logic [1:0]  st_off,
    input  mem_size_e   st_size,
    input  logic [31:0] st_data,
    output logic [3:0]  st_strb,
    output logic [31:0] st_lanes,
    input  logic [1:0]  ld_off,
    input  mem_size_e   ld_size,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_strb  = 4'hF;
        st_lanes = st_data;
        unique case (st_size)
            MEM_BYTE, MEM_BYTE_U: begin
                st_strb  = 4'b0001 << st_off;
                st_lanes = {4{st_data[7:0]}};
            end
            MEM_HALF, MEM_HALF_U: begin
                st_strb  = 4'b0011 << {st_off[1], 1'b0};
                st_lanes = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = ld_word[{ld_off, 3'b000} +: 8];
        ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
        unique case (ld_size)
            MEM_BYTE:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            MEM_BYTE_U: ld_data = {24'h0, ld_byte};
            MEM_HALF:   ld_data = {{16{ld_half[15]}}, ld_half};
            MEM_HALF_U: ld_data = {16'h0, ld_half};
            default:    ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/core_stage_mem.sv
// MEM stage: single-outstanding bus master with load alignment and LR/SC reservation.
// Define CORE_MEM_RSV_EN to build the reservation register; otherwise every SC fails.
module core_stage_mem
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_stage_valid,
    output logic        mem_stage_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  mem_dir_e    mem_dir,
    input  mem_size_e   mem_size,
    input  mem_rsv_e    mem_rsv,
    output logic        mem_rsv_valid,
    output logic [31:0] mem_last_rdata,
    input  logic        rsv_kill,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [29:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_resp_err,
    output logic        ex_load_fault,
    output logic        ex_store_fault
);

    mem_state_e  state, state_nx;
    logic        accept, done, is_write;
    logic [1:0]  off_q;
    mem_size_e   size_q;
    logic [3:0]  st_strb;
    logic [31:0] st_lanes, ld_data;

    assign is_write = (mem_dir == MEM_WRITE);

    core_mem_lane u_lane (
        .st_off   (mem_addr[1:0]),
        .st_size  (mem_size),
        .st_data  (mem_wdata),
        .st_strb  (st_strb),
        .st_lanes (st_lanes),
        .ld_off   (off_q),
        .ld_size  (size_q),
        .ld_word  (bus_rdata),
        .ld_data  (ld_data)
    );

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        done     = 1'b0;
        unique case (state)
            MEM_IDLE: if (mem_stage_valid) begin
                accept   = 1'b1;
                state_nx = MEM_REQ;
            end
            MEM_REQ: if (bus_req_ready) state_nx = MEM_WAIT;
            MEM_WAIT: if (bus_resp_valid) begin
                done     = 1'b1;
                state_nx = MEM_IDLE;
            end
            default: state_nx = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MEM_IDLE;
        else     state <= state_nx;
    end

    assign bus_req_valid   = (state == MEM_REQ);
    assign mem_stage_ready = done;
    assign ex_load_fault   = done & bus_resp_err & ~bus_we;
    assign ex_store_fault  = done & bus_resp_err & bus_we;

    // Payload is captured once at acceptance and held until the bus takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_addr  <= '0;
            bus_we    <= 1'b0;
            bus_wstrb <= '0;
            bus_wdata <= '0;
            off_q     <= '0;
            size_q    <= MEM_BYTE;
        end else if (accept) begin
            bus_addr  <= mem_addr[31:2];
            bus_we    <= is_write;
            bus_wstrb <= is_write ? st_strb : 4'h0;
            bus_wdata <= is_write ? st_lanes : 32'h0;
            off_q     <= mem_addr[1:0];
            size_q    <= mem_size;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  mem_last_rdata <= '0;
        else if (done && !bus_we && !bus_resp_err) mem_last_rdata <= ld_data;
    end

`ifdef CORE_MEM_RSV_EN
    mem_rsv_e    rsv_q;
    logic        rsv_v;
    logic [29:0] rsv_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rsv_q <= RSV_NONE;
        else if (accept) rsv_q <= mem_rsv;
    end

    // Kill wins over a same-cycle LR completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsv_v <= 1'b0;
            rsv_a <= '0;
        end else if (rsv_kill) begin
            rsv_v <= 1'b0;
        end else if (done && !bus_we && !bus_resp_err && rsv_q == RSV_SET) begin
            rsv_v <= 1'b1;
            rsv_a <= bus_addr;
        end else if (done && bus_we && rsv_q == RSV_CLEAR) begin
            rsv_v <= 1'b0;
        end
    end

    assign mem_rsv_valid = rsv_v && (rsv_a == mem_addr[31:2]);
`else
    logic unused_rsv;
    assign unused_rsv    = ^{rsv_kill, mem_rsv};
    assign mem_rsv_valid = 1'b0;
`endif

endmodule

// File: tb/tb_core_stage_mem.sv
// Randomized bench for core_stage_mem against a transaction-level model.
module tb_core_stage_mem;
    import core_pkg::*;

`ifdef CORE_MEM_RSV_EN
    localparam bit RSV_EN = 1'b1;
`else
    localparam bit RSV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_stage_valid, mem_stage_ready;
    logic [31:0] mem_addr, mem_wdata;
    mem_dir_e    mem_dir;
    mem_size_e   mem_size;
    mem_rsv_e    mem_rsv;
    logic        mem_rsv_valid;
    logic [31:0] mem_last_rdata;
    logic        rsv_kill;
    logic        bus_req_valid, bus_req_ready;
    logic [29:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_resp_valid, bus_resp_err;
    logic [31:0] bus_rdata;
    logic        ex_load_fault, ex_store_fault;

    always #5 clk = ~clk;

    core_stage_mem dut (
        .clk(clk), .rst(rst),
        .mem_stage_valid(mem_stage_valid), .mem_stage_ready(mem_stage_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_dir(mem_dir),
        .mem_size(mem_size), .mem_rsv(mem_rsv), .mem_rsv_valid(mem_rsv_valid),
        .mem_last_rdata(mem_last_rdata), .rsv_kill(rsv_kill),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_wstrb(bus_wstrb),
        .bus_wdata(bus_wdata), .bus_resp_valid(bus_resp_valid),
        .bus_rdata(bus_rdata), .bus_resp_err(bus_resp_err),
        .ex_load_fault(ex_load_fault), .ex_store_fault(ex_store_fault)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state
    bit          m_rsv_v;
    logic [29:0] m_rsv_a;
    logic [31:0] m_last;
    bit          p_load, p_set, p_clr;
    logic [31:0] p_data;
    logic [29:0] p_a;

    // Expected outputs for the current cycle
    bit          chk;
    bit          e_ready, e_breq, e_we, e_lf, e_sf;
    logic [29:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;

    function automatic logic [31:0] load_ext(logic [31:0] w, logic [1:0] o, mem_size_e s);
        logic [31:0] b, h;
        b = (w >> (8 * o)) & 32'hFF;
        h = (w >> (16 * o[1])) & 32'hFFFF;
        case (s)
            MEM_BYTE:   return (b >= 128) ? b + 32'hFFFFFF00 : b;
            MEM_BYTE_U: return b;
            MEM_HALF:   return (h >= 32768) ? h + 32'hFFFF0000 : h;
            MEM_HALF_U: return h;
            default:    return w;
        endcase
    endfunction

    function automatic logic [3:0] st_strb(logic [1:0] o, mem_size_e s);
        case (s)
            MEM_BYTE, MEM_BYTE_U: return 4'(1 << o);
            MEM_HALF, MEM_HALF_U: return 4'(3 << (2 * o[1]));
            default:              return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] st_data(logic [31:0] w, mem_size_e s);
        case (s)
            MEM_BYTE, MEM_BYTE_U: return (w & 32'hFF) * 32'h01010101;
            MEM_HALF, MEM_HALF_U: return (w & 32'hFFFF) * 32'h00010001;
            default:              return w;
        endcase
    endfunction

    function automatic bit exp_rsv();
        return RSV_EN && m_rsv_v && (m_rsv_a == mem_addr[31:2]);
    endfunction

    always @(negedge clk) begin
        if (chk) begin
            check("ready", mem_stage_ready, e_ready);
            check("bus_req_valid", bus_req_valid, e_breq);
            check("load_fault", ex_load_fault, e_lf);
            check("store_fault", ex_store_fault, e_sf);
            check("last_rdata", mem_last_rdata, m_last);
            check("rsv_valid", mem_rsv_valid, exp_rsv());
            if (e_breq) begin
                check("bus_addr", bus_addr, e_addr);
                check("bus_we", bus_we, e_we);
                if (e_we) begin
                    check("bus_wstrb", bus_wstrb, e_strb);
                    check("bus_wdata", bus_wdata, e_wdata);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (p_load) m_last = p_data;
        if (p_set) begin
            m_rsv_v = 1'b1;
            m_rsv_a = p_a;
        end
        if (p_clr) m_rsv_v = 1'b0;
        p_load = 0; p_set = 0; p_clr = 0;
        e_ready = 0; e_breq = 0; e_lf = 0; e_sf = 0;
        bus_req_ready = 0; bus_resp_valid = 0; bus_resp_err = 0; rsv_kill = 0;
    endtask

    task automatic idle(int n, logic [31:0] a, bit kill);
        for (int i = 0; i < n; i++) begin
            step();
            mem_stage_valid = 0;
            mem_addr = a;
            rsv_kill = kill;
            if (kill) p_clr = 1;
        end
    endtask

    task automatic pin(string name, logic [31:0] act, logic [31:0] exp);
        #1;
        check(name, act, exp);
    endtask

    task automatic txn(logic [31:0] a, logic [31:0] wd, mem_dir_e d, mem_size_e s,
                       mem_rsv_e r, int rq, int rs, bit err, bit kill, logic [31:0] rd);
        bit w;
        w = (d == MEM_WRITE);
        step();
        mem_stage_valid = 1; mem_addr = a; mem_wdata = wd;
        mem_dir = d; mem_size = s; mem_rsv = r;
        for (int i = 0; i <= rq; i++) begin
            step();
            e_breq = 1; e_addr = a[31:2]; e_we = w;
            e_strb = st_strb(a[1:0], s); e_wdata = st_data(wd, s);
            bus_req_ready = (i == rq);
            bus_rdata = $urandom;
        end
        for (int j = 0; j <= rs; j++) begin
            step();
            bus_rdata = $urandom;
            bus_resp_err = 1'($urandom);
            if (j == rs) begin
                bus_resp_valid = 1; bus_resp_err = err; bus_rdata = rd; rsv_kill = kill;
                e_ready = 1; e_lf = err & !w; e_sf = err & w;
                if (!w && !err) begin
                    p_load = 1;
                    p_data = load_ext(rd, a[1:0], s);
                end
                if (kill) p_clr = 1;
                else if (!w && !err && r == RSV_SET) begin
                    p_set = 1;
                    p_a = a[31:2];
                end else if (w && r == RSV_CLEAR) p_clr = 1;
            end
        end
    endtask

    initial begin
        rst = 1; chk = 0;
        mem_stage_valid = 0; mem_addr = 0; mem_wdata = 0;
        mem_dir = MEM_READ; mem_size = MEM_WORD; mem_rsv = RSV_NONE;
        rsv_kill = 0; bus_req_ready = 0; bus_resp_valid = 0;
        bus_rdata = 0; bus_resp_err = 0;
        m_rsv_v = 0; m_rsv_a = 0; m_last = 0;
        p_load = 0; p_set = 0; p_clr = 0; p_data = 0; p_a = 0;
        e_ready = 0; e_breq = 0; e_we = 0; e_lf = 0; e_sf = 0;
        e_addr = 0; e_strb = 0; e_wdata = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", mem_stage_ready, 0);
        check("rst_breq", bus_req_valid, 0);
        check("rst_last", mem_last_rdata, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_wstrb", bus_wstrb, 0);
        check("rst_rsv", mem_rsv_valid, 0);
        rst = 0;
        chk = 1;

        check("model_strb", st_strb(2'b10, MEM_HALF), 4'b1100);
        check("model_wdata", st_data(32'hDEADBEEF, MEM_HALF), 32'hBEEFBEEF);
        txn(32'h1002, 32'hDEADBEEF, MEM_WRITE, MEM_HALF, RSV_NONE, 0, 0, 0, 0, 0);
        idle(1, 0, 0);

        txn(32'h2003, 0, MEM_READ, MEM_BYTE, RSV_NONE, 0, 0, 0, 0, 32'h80000000);
        idle(1, 0, 0);
        pin("lb_sext", mem_last_rdata, 32'hFFFFFF80);
        txn(32'h2003, 0, MEM_READ, MEM_BYTE_U, RSV_NONE, 0, 0, 0, 0, 32'h80000000);
        idle(1, 0, 0);
        pin("lbu_zext", mem_last_rdata, 32'h00000080);

        txn(32'h3000, 0, MEM_READ, MEM_WORD, RSV_SET, 0, 1, 1, 0, 32'h12345678);
        idle(1, 32'h3000, 0);
        pin("lr_err_rdata", mem_last_rdata, 32'h00000080);
        pin("lr_err_rsv", mem_rsv_valid, 0);

        txn(32'h3000, 0, MEM_READ, MEM_WORD, RSV_SET, 0, 0, 0, 0, 32'hCAFEF00D);
        idle(1, 32'h3004, 0);
        pin("lr_other", mem_rsv_valid, 0);
        idle(1, 32'h3000, 0);
        pin("lr_match", mem_rsv_valid, 32'(RSV_EN));
        txn(32'h3000, 32'h55, MEM_WRITE, MEM_WORD, RSV_CLEAR, 0, 0, 0, 0, 0);
        idle(1, 32'h3000, 0);
        pin("sc_clear", mem_rsv_valid, 0);

        txn(32'h3000, 0, MEM_READ, MEM_WORD, RSV_SET, 0, 0, 0, 1, 32'h1);
        idle(1, 32'h3000, 0);
        pin("lr_kill", mem_rsv_valid, 0);

        txn(32'h4001, 32'hA5, MEM_WRITE, MEM_BYTE, RSV_NONE, 3, 2, 0, 0, 0);
        txn(32'h4000, 0, MEM_READ, MEM_HALF, RSV_NONE, 3, 0, 0, 0, 32'h0000F00F);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = {20'h0, 8'($urandom_range(0, 3)), 4'h0} | 32'($urandom_range(0, 15));
            txn(a, $urandom, mem_dir_e'($urandom_range(0, 1)),
                mem_size_e'($urandom_range(0, 4)), mem_rsv_e'($urandom_range(0, 2)),
                $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), $urandom);
            idle($urandom_range(0, 2), a ^ 32'($urandom_range(0, 1) << 2),
                 ($urandom_range(0, 9) == 0));
        end

        txn(32'h3000, 0, MEM_READ, MEM_WORD, RSV_SET, 0, 0, 0, 0, 32'h7777);
        idle(1, 32'h3000, 0);
        step();
        mem_stage_valid = 1; mem_addr = 32'h3000; mem_dir = MEM_READ;
        mem_size = MEM_WORD; mem_rsv = RSV_NONE;
        step();
        e_breq = 1; e_addr = 30'h0C00; e_we = 0;
        bus_req_ready = 1;
        step();
        #1;
        rst = 1;
        chk = 0;
        #1;
        check("wait_rst_breq", bus_req_valid, 0);
        check("wait_rst_ready", mem_stage_ready, 0);
        check("wait_rst_last", mem_last_rdata, 0);
        check("wait_rst_rsv", mem_rsv_valid, 0);
        check("wait_rst_addr", bus_addr, 0);
        m_last = 0; m_rsv_v = 0;
        step();
        rst = 0;
        mem_stage_valid = 0;
        chk = 1;
        txn(32'h5002, 0, MEM_READ, MEM_HALF, RSV_NONE, 0, 0, 0, 0, 32'h80010000);
        idle(2, 0, 0);
        pin("post_rst_lh", mem_last_rdata, 32'hFFFF8001);

        chk = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
